// File: rtl/id_scoreboard.sv
// id_scoreboard
//   Decode-stage register scoreboard. Each architectural register (except r0)
//   has a small counter of outstanding writes. The ID instruction's sources
//   are stalled while their counter is nonzero. The ID instruction's
//   destination is stalled while its counter is saturated. Issue events
//   increment the counters and WB retire events decrement them.
//
//   Optional feature macro: SB_WB_BYPASS_EN
//     When defined, a source whose counter is 1 and which is being retired in
//     the same cycle is reported not busy, because ID takes the WB-forwarded
//     value.
//
// Ports
//   clk, resetn      clock, asynchronous active-low reset
//   src_addr/used    NUM_SRC source addresses (port i at [i*AW +: AW]) and use flags
//   id_dest/id_we    destination of the ID instruction
//   issue_valid      ID instruction leaves ID this cycle
//   wb_valid/dest    register write in WB this cycle
//   flush            clear all in-flight tracking at the next edge
//   src_busy         per-source outstanding-write indication (combinational)
//   dest_full        id_we and the destination counter is saturated
//   ready_go         no used source busy and not dest_full
//   inflight_total   saturating count of tracked outstanding writes
//   err_overflow     sticky: issue attempted on a saturated counter
//   err_underflow    sticky: retire seen on a zero counter
module id_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int AW       = 5,
  parameter int NUM_SRC  = 2,
  parameter int CNT_W    = 2,
  parameter int TOT_W    = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [NUM_SRC*AW-1:0] src_addr,
  input  logic [NUM_SRC-1:0]    src_used,
  input  logic [AW-1:0]         id_dest,
  input  logic                  id_we,
  input  logic                  issue_valid,
  input  logic                  wb_valid,
  input  logic [AW-1:0]         wb_dest,
  input  logic                  flush,
  output logic [NUM_SRC-1:0]    src_busy,
  output logic                  dest_full,
  output logic                  ready_go,
  output logic [TOT_W-1:0]      inflight_total,
  output logic                  err_overflow,
  output logic                  err_underflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [TOT_W-1:0] TOT_MAX = {TOT_W{1'b1}};
  localparam logic [TOT_W-1:0] TOT_ONE = {{(TOT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_reg  [NUM_REGS];
  logic [CNT_W-1:0] cnt_next [NUM_REGS];
  logic [TOT_W-1:0] total_reg, total_next;
  logic             err_ovf_reg, err_udf_reg;

  logic [CNT_W-1:0] id_cnt, wb_cnt;
  logic issue_try, retire_try, same_reg;
  logic do_inc, do_dec, ovf_evt, udf_evt;

  assign id_cnt = cnt_reg[id_dest];
  assign wb_cnt = cnt_reg[wb_dest];

  assign dest_full  = id_we && (id_cnt == CNT_MAX);
  assign issue_try  = issue_valid && id_we && (id_dest != '0);
  assign retire_try = wb_valid && (wb_dest != '0);
  // Issue and retire to the same register cancel out. Neither one is checked
  // against the counter limits in that case.
  assign same_reg   = issue_try && retire_try && (id_dest == wb_dest);

  assign do_inc  = issue_try && !dest_full && !same_reg;
  assign do_dec  = retire_try && (wb_cnt != '0) && !same_reg;
  assign ovf_evt = issue_try && dest_full && !same_reg;
  assign udf_evt = retire_try && (wb_cnt == '0) && !same_reg;

  // Source busy checks
  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
      logic [AW-1:0]    addr;
      logic [CNT_W-1:0] cnt;
      assign addr = src_addr[gi*AW +: AW];
      assign cnt  = cnt_reg[addr];
`ifdef SB_WB_BYPASS_EN
      // The last outstanding write retiring now is forwarded from WB.
      assign src_busy[gi] = src_used[gi] && (addr != '0) && (cnt != '0) &&
                            !((cnt == CNT_ONE) && retire_try && (wb_dest == addr));
`else
      assign src_busy[gi] = src_used[gi] && (addr != '0) && (cnt != '0);
`endif
    end
  endgenerate

  assign ready_go = ~|src_busy && !dest_full;

  // Per-register next-state; r0 is hard-wired to zero
  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_cnt
      if (gi == 0) begin : g_zero
        assign cnt_next[gi] = '0;
      end else begin : g_track
        assign cnt_next[gi] = flush ? '0 :
                              (do_inc && (id_dest == AW'(gi))) ? cnt_reg[gi] + CNT_ONE :
                              (do_dec && (wb_dest == AW'(gi))) ? cnt_reg[gi] - CNT_ONE :
                              cnt_reg[gi];
      end
    end
  endgenerate

  always_comb begin
    total_next = total_reg;
    if (flush) begin
      total_next = '0;
    end else if (do_inc && !do_dec) begin
      if (total_reg != TOT_MAX) total_next = total_reg + TOT_ONE;
    end else if (do_dec && !do_inc) begin
      if (total_reg != '0) total_next = total_reg - TOT_ONE;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_REGS; i++) cnt_reg[i] <= '0;
      total_reg   <= '0;
      err_ovf_reg <= 1'b0;
      err_udf_reg <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) cnt_reg[i] <= cnt_next[i];
      total_reg   <= total_next;
      // Flush suppresses the concurrent events, so they cannot raise errors.
      // Flush does not clear errors that are already set.
      err_ovf_reg <= err_ovf_reg | (ovf_evt && !flush);
      err_udf_reg <= err_udf_reg | (udf_evt && !flush);
    end
  end

  assign inflight_total = total_reg;
  assign err_overflow   = err_ovf_reg;
  assign err_underflow  = err_udf_reg;

endmodule

// File: tb/tb_id_scoreboard.sv
// Directed testbench for id_scoreboard (default parameters).
module tb_id_scoreboard;

  logic        clk = 1'b0;
  logic        resetn;
  logic [9:0]  src_addr;
  logic [1:0]  src_used;
  logic [4:0]  id_dest;
  logic        id_we;
  logic        issue_valid;
  logic        wb_valid;
  logic [4:0]  wb_dest;
  logic        flush;
  logic [1:0]  src_busy;
  logic        dest_full;
  logic        ready_go;
  logic [3:0]  inflight_total;
  logic        err_overflow;
  logic        err_underflow;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  id_scoreboard dut (
    .clk(clk), .resetn(resetn), .src_addr(src_addr), .src_used(src_used),
    .id_dest(id_dest), .id_we(id_we), .issue_valid(issue_valid),
    .wb_valid(wb_valid), .wb_dest(wb_dest), .flush(flush),
    .src_busy(src_busy), .dest_full(dest_full), .ready_go(ready_go),
    .inflight_total(inflight_total), .err_overflow(err_overflow),
    .err_underflow(err_underflow)
  );

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_one(input logic [4:0] d);
    id_we = 1'b1; id_dest = d; issue_valid = 1'b1;
    tick();
    issue_valid = 1'b0; id_we = 1'b0; id_dest = '0;
  endtask

  task automatic retire_one(input logic [4:0] d);
    wb_valid = 1'b1; wb_dest = d;
    tick();
    wb_valid = 1'b0; wb_dest = '0;
  endtask

  task automatic set_src(input logic [4:0] a0, input logic [4:0] a1, input logic [1:0] used);
    src_addr = {a1, a0}; src_used = used;
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; src_addr = {5'd2, 5'd1}; src_used = 2'b11;
    id_dest = 5'd1; id_we = 1'b1; issue_valid = 1'b0;
    wb_valid = 1'b0; wb_dest = '0; flush = 1'b0;
    tick(); tick();
    n_tests++; if ({src_busy, dest_full, ready_go} !== 4'b0001) begin
      n_fail++; $display("FAIL reset_comb: got busy=%b full=%b rg=%b want busy=00 full=0 rg=1", src_busy, dest_full, ready_go);
    end
    n_tests++; if ({inflight_total, err_overflow, err_underflow} !== 6'b0) begin
      n_fail++; $display("FAIL reset_state: got tot=%0d ovf=%b udf=%b want 0 0 0", inflight_total, err_overflow, err_underflow);
    end
    resetn = 1'b1; id_we = 1'b0; id_dest = '0; src_used = 2'b00;
    tick();
    $display("[TB] reset done");
  endtask

  task automatic test_issue_busy();
    issue_one(5'd5);
    set_src(5'd5, 5'd0, 2'b01);
    n_tests++; if ({src_busy, ready_go, inflight_total} !== {2'b01, 1'b0, 4'd1}) begin
      n_fail++; $display("FAIL issue_busy: got busy=%b rg=%b tot=%0d want busy=01 rg=0 tot=1", src_busy, ready_go, inflight_total);
    end
    $display("[TB] issue r5 -> busy=%b tot=%0d", src_busy, inflight_total);
  endtask

  task automatic test_retire();
    logic exp_same;
`ifdef SB_WB_BYPASS_EN
    exp_same = 1'b0;
`else
    exp_same = 1'b1;
`endif
    wb_valid = 1'b1; wb_dest = 5'd5;
    #1;
    n_tests++; if (src_busy[0] !== exp_same) begin
      n_fail++; $display("FAIL retire_same_cycle: got busy0=%b want %b", src_busy[0], exp_same);
    end
    tick();
    wb_valid = 1'b0; wb_dest = '0;
    #1;
    n_tests++; if ({src_busy[0], ready_go, inflight_total} !== {1'b0, 1'b1, 4'd0}) begin
      n_fail++; $display("FAIL retire_after: got busy0=%b rg=%b tot=%0d want 0 1 0", src_busy[0], ready_go, inflight_total);
    end
    $display("[TB] retire r5 -> busy=%b tot=%0d", src_busy, inflight_total);
  endtask

  task automatic test_dest_full();
    set_src(5'd0, 5'd0, 2'b00);
    for (int k = 0; k < 3; k++) issue_one(5'd7);
    id_we = 1'b1; id_dest = 5'd7;
    #1;
    n_tests++; if ({dest_full, ready_go, inflight_total} !== {1'b1, 1'b0, 4'd3}) begin
      n_fail++; $display("FAIL dest_full: got full=%b rg=%b tot=%0d want 1 0 3", dest_full, ready_go, inflight_total);
    end
    n_tests++; if (err_overflow !== 1'b0) begin
      n_fail++; $display("FAIL ovf_premature: got %b want 0", err_overflow);
    end
    issue_one(5'd7);
    id_we = 1'b1; id_dest = 5'd7;
    #1;
    n_tests++; if ({err_overflow, dest_full, inflight_total} !== {1'b1, 1'b1, 4'd3}) begin
      n_fail++; $display("FAIL overflow: got ovf=%b full=%b tot=%0d want 1 1 3", err_overflow, dest_full, inflight_total);
    end
    id_we = 1'b0; id_dest = '0;
    for (int k = 0; k < 3; k++) retire_one(5'd7);
    set_src(5'd7, 5'd0, 2'b01);
    n_tests++; if ({src_busy, inflight_total, err_underflow} !== {2'b00, 4'd0, 1'b0}) begin
      n_fail++; $display("FAIL drain_r7: got busy=%b tot=%0d udf=%b want 00 0 0", src_busy, inflight_total, err_underflow);
    end
    $display("[TB] r7 saturate -> ovf=%b tot=%0d", err_overflow, inflight_total);
  endtask

  task automatic test_same_cycle();
    issue_one(5'd9);
    id_we = 1'b1; id_dest = 5'd9; issue_valid = 1'b1;
    wb_valid = 1'b1; wb_dest = 5'd9;
    tick();
    id_we = 1'b0; id_dest = '0; issue_valid = 1'b0; wb_valid = 1'b0; wb_dest = '0;
    set_src(5'd9, 5'd0, 2'b01);
    n_tests++; if ({src_busy, inflight_total, err_underflow, err_overflow} !== {2'b01, 4'd1, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL same_reg: got busy=%b tot=%0d udf=%b ovf=%b want 01 1 0 1", src_busy, inflight_total, err_underflow, err_overflow);
    end
    retire_one(5'd9);
    #1;
    n_tests++; if ({src_busy, inflight_total} !== {2'b00, 4'd0}) begin
      n_fail++; $display("FAIL same_reg_drain: got busy=%b tot=%0d want 00 0", src_busy, inflight_total);
    end
    $display("[TB] issue+retire r9 -> busy=%b tot=%0d", src_busy, inflight_total);
  endtask

  task automatic test_back_to_back();
    issue_one(5'd10);
    id_we = 1'b1; id_dest = 5'd11; issue_valid = 1'b1;
    wb_valid = 1'b1; wb_dest = 5'd10;
    tick();
    id_we = 1'b0; id_dest = '0; issue_valid = 1'b0; wb_valid = 1'b0; wb_dest = '0;
    set_src(5'd10, 5'd11, 2'b11);
    n_tests++; if ({src_busy, inflight_total} !== {2'b10, 4'd1}) begin
      n_fail++; $display("FAIL diff_regs: got busy=%b tot=%0d want 10 1", src_busy, inflight_total);
    end
    retire_one(5'd11);
    #1;
    n_tests++; if ({src_busy, inflight_total} !== {2'b00, 4'd0}) begin
      n_fail++; $display("FAIL diff_drain: got busy=%b tot=%0d want 00 0", src_busy, inflight_total);
    end
    $display("[TB] issue r11 + retire r10 -> busy=%b tot=%0d", src_busy, inflight_total);
  endtask

  task automatic test_flush();
    issue_one(5'd3);
    issue_one(5'd4);
    issue_one(5'd4);
    set_src(5'd3, 5'd4, 2'b11);
    n_tests++; if ({src_busy, inflight_total} !== {2'b11, 4'd3}) begin
      n_fail++; $display("FAIL pre_flush: got busy=%b tot=%0d want 11 3", src_busy, inflight_total);
    end
    flush = 1'b1; id_we = 1'b1; id_dest = 5'd6; issue_valid = 1'b1;
    tick();
    flush = 1'b0; id_we = 1'b0; id_dest = '0; issue_valid = 1'b0;
    #1;
    n_tests++; if ({src_busy, ready_go, inflight_total} !== {2'b00, 1'b1, 4'd0}) begin
      n_fail++; $display("FAIL flush: got busy=%b rg=%b tot=%0d want 00 1 0", src_busy, ready_go, inflight_total);
    end
    set_src(5'd6, 5'd0, 2'b01);
    n_tests++; if ({src_busy, err_overflow} !== {2'b00, 1'b1}) begin
      n_fail++; $display("FAIL flush_r6: got busy=%b ovf=%b want 00 1", src_busy, err_overflow);
    end
    $display("[TB] flush -> busy=%b tot=%0d", src_busy, inflight_total);
  endtask

  task automatic test_reg_zero();
    issue_one(5'd0);
    set_src(5'd0, 5'd0, 2'b11);
    n_tests++; if ({src_busy, ready_go, inflight_total} !== {2'b00, 1'b1, 4'd0}) begin
      n_fail++; $display("FAIL r0: got busy=%b rg=%b tot=%0d want 00 1 0", src_busy, ready_go, inflight_total);
    end
    retire_one(5'd8);
    #1;
    n_tests++; if ({err_underflow, inflight_total} !== {1'b1, 4'd0}) begin
      n_fail++; $display("FAIL underflow: got udf=%b tot=%0d want 1 0", err_underflow, inflight_total);
    end
    $display("[TB] r0 issue, r8 retire -> udf=%b", err_underflow);
  endtask

  task automatic test_total_sat();
    // Six registers times three writes each: 18 accepted issues, total clamps at 15.
    for (int r = 1; r <= 6; r++)
      for (int k = 0; k < 3; k++) issue_one(5'(r));
    #1;
    n_tests++; if (inflight_total !== 4'd15) begin
      n_fail++; $display("FAIL total_sat: got tot=%0d want 15", inflight_total);
    end
    $display("[TB] total saturation -> tot=%0d", inflight_total);
  endtask

  task automatic test_async_reset();
    set_src(5'd1, 5'd6, 2'b11);
    n_tests++; if (src_busy !== 2'b11) begin
      n_fail++; $display("FAIL pre_async: got busy=%b want 11", src_busy);
    end
    #2;
    resetn = 1'b0;
    #1;
    n_tests++; if ({src_busy, ready_go, inflight_total, err_overflow, err_underflow} !== {2'b00, 1'b1, 4'd0, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL async_reset: got busy=%b rg=%b tot=%0d ovf=%b udf=%b want 00 1 0 0 0", src_busy, ready_go, inflight_total, err_overflow, err_underflow);
    end
    tick();
    resetn = 1'b1;
    tick();
    $display("[TB] async reset -> tot=%0d", inflight_total);
  endtask

  initial begin
    test_reset();
    test_issue_busy();
    test_retire();
    test_dest_full();
    test_same_cycle();
    test_back_to_back();
    test_flush();
    test_reg_zero();
    test_total_sat();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/id_scoreboard.md
Name: id_scoreboard

Overview:
- Parametrised register scoreboard for the decode stage.
- Generalises the fixed single-EXE-stage load-use check into per-register outstanding-write counters, so multi-cycle units (mul/div, loads) and any pipeline depth are handled uniformly.
- ID presents its source registers and destination each cycle and receives a single ready_go qualifier.
- Issue (ID->EXE handshake) and retire (WB register write) events update the counters.

Parameters:
- NUM_REGS, 32: architectural registers tracked; register 0 is never tracked.
- AW, 5: register address width; clog2(NUM_REGS).
- NUM_SRC, 2: source operand ports checked per cycle.
- CNT_W, 2: per-register counter width; max outstanding writes per register = 2^CNT_W-1.
- TOT_W, 4: width of the total in-flight counter; saturates at 2^TOT_W-1.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- src_addr  in  NUM_SRC*AW  source register addresses; port i at bits [i*AW +: AW]
- src_used  in  NUM_SRC  source port i is read by the ID instruction
- id_dest  in  AW  destination of the ID instruction
- id_we  in  1  ID instruction writes a register
- issue_valid  in  1  ID instruction leaves ID this cycle (ID_to_EXE_valid && EXE_allowin)
- wb_valid  in  1  WB writes a register this cycle
- wb_dest  in  AW  WB destination
- flush  in  1  cancel all in-flight tracking (exception/ertn)
- src_busy  out  NUM_SRC  source i has an outstanding write
- dest_full  out  1  id_we && counter[id_dest] at maximum
- ready_go  out  1  no used source busy and not dest_full
- inflight_total  out  TOT_W  number of tracked outstanding writes
- err_overflow  out  1  sticky: issue attempted on saturated counter
- err_underflow  out  1  sticky: retire on zero counter

Behaviour:
- Reset (asynchronous, resetn low): all counters 0, inflight_total 0, both error flags 0. Combinational outputs follow: src_busy 0, dest_full 0, ready_go 1.
- Reset asserted mid-operation clears state immediately, independent of clk.
- Issue event: issue_valid && id_we && id_dest!=0 && !dest_full. Increments counter[id_dest] at the next posedge.
- Issue with dest_full set: no increment; err_overflow set.
- Retire event: wb_valid && wb_dest!=0.
  - Counter nonzero: decrements counter[wb_dest].
  - Counter zero: unchanged; err_underflow set.
- Issue and retire on the same register in the same cycle: counter unchanged; no error, even if the counter is saturated or zero.
- Issue and retire on different registers in the same cycle: both applied.
- flush: at the next posedge all counters and inflight_total go to 0; concurrent issue/retire ignored (flush wins). Error flags are not cleared by flush; only reset clears them.
- src_busy[i] = src_used[i] && src_addr[i]!=0 && counter[src_addr[i]]!=0. Combinational, zero latency.
- ready_go = ~|src_busy && !dest_full. Combinational.
- inflight_total: +1 on each accepted issue, -1 on each accepted retire, net 0 when both occur.
  - Saturates at max; does not go below 0.
- Register 0 is never read as busy and never counted.
- The caller must not retire instructions that were flushed.

Optional Feature:
- Macro SB_WB_BYPASS_EN.
- Defined: a source is not busy when counter==1 and a retire event to that register occurs in the same cycle (same-cycle WB bypass). ID consumes the WB forwarded value.
- Not defined: the source stays busy until the cycle after the retire.

Test Plan:
- Reset, then issue id_dest=5 id_we=1 -> next cycle src_addr0=5 src_used0=1 gives src_busy[0]=1, ready_go=0, inflight_total=1.
- wb_valid wb_dest=5 -> without macro, src_busy[0] low one cycle after the retire; with SB_WB_BYPASS_EN, low in the same cycle. inflight_total=0.
- Issue to r7 three times (CNT_W=2) -> dest_full=1 with id_dest=7; a fourth issue_valid sets err_overflow=1 and the counter stays 3.
- Issue r9 and retire r9 in the same cycle with counter[9]=1 -> counter stays 1, src_busy stays 1, no error flag.
- Counters r3=1, r4=2, then flush together with an issue to r6 -> all counters 0, inflight_total=0, ready_go=1.
- id_dest=0 issued, and src_addr=0 used -> no counter change, src_busy=0. wb to r8 with counter 0 -> err_underflow=1. resetn low mid-cycle clears all state asynchronously.
